// File: rtl/mc_pkg.sv
// Shared state, opcode and mux-select encodings for the multi-cycle controller.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_R_WB     = 4'd3,
      ST_EXEC_I   = 4'd4,
      ST_I_WB     = 4'd5,
      ST_MEM_ADDR = 4'd6,
      ST_MEM_RD   = 4'd7,
      ST_MEM_WR   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_LW_WB    = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_BEQ   = 6'd4;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // States that hold a request on the shared memory and wait for mem_ready.
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts wait cycles of an outstanding memory access and flags a bus timeout.
module mc_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_active,
   input  logic i_ready,
   output logic o_timeout
);

   logic [CNT_W-1:0] r_cnt;

   // A ready on the limit cycle completes the access, so it masks the timeout.
   assign o_timeout = i_active && !i_ready && (r_cnt == CNT_W'(MEM_TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset || !i_active || i_ready || o_timeout) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback over a shared datapath.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] ir_op,
   input  logic       mem_ready,
   input  logic       alu_zero,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal_op,
   output logic       bus_err,
   output logic [3:0] state_o
);

   state_t r_state;
   state_t w_state_next;
   logic   w_mem_state;
   logic   w_timeout;
   logic   w_op_legal;

   assign w_mem_state = is_mem_state(r_state);
   assign w_op_legal  = ir_op inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ};

   mc_mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .i_active  (w_mem_state),
      .i_ready   (mem_ready),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         // A fetch timeout simply stays in FETCH so the same PC is requested again.
         ST_FETCH: begin
            if (mem_ready) w_state_next = ST_DECODE;
         end
         ST_DECODE: begin
            case (ir_op)
               OP_RTYPE:     w_state_next = ST_EXEC_R;
               OP_LW, OP_SW: w_state_next = ST_MEM_ADDR;
               OP_ADDI:      w_state_next = ST_EXEC_I;
               OP_BEQ:       w_state_next = ST_BRANCH;
               default:      w_state_next = ST_FETCH;
            endcase
         end
         ST_EXEC_R: w_state_next = ST_R_WB;
         ST_EXEC_I: w_state_next = ST_I_WB;
         ST_MEM_ADDR: begin
            if (ir_op == OP_SW) w_state_next = ST_MEM_WR;
            else                w_state_next = ST_MEM_RD;
         end
         ST_MEM_RD: begin
            if (mem_ready)      w_state_next = ST_LW_WB;
            else if (w_timeout) w_state_next = ST_FETCH;
         end
         ST_MEM_WR: begin
            if (mem_ready || w_timeout) w_state_next = ST_FETCH;
         end
         default: w_state_next = ST_FETCH;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op        = ALU_ADD;
      illegal_op    = 1'b0;
      bus_err       = 1'b0;
      state_o       = ST_FETCH;
      if (!reset) begin
         state_o = r_state;
         bus_err = w_timeout;
         case (r_state)
            ST_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: begin
               alu_src_b  = SRCB_IMM_SH2;
               illegal_op = !w_op_legal;
            end
            ST_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
               reg_dst   = 1'b1;
               reg_write = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            ST_I_WB: reg_write = 1'b1;
            ST_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            ST_MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            ST_LW_WB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
            end
            // Conditional PC load is qualified with the compare result here.
            ST_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_SUB;
               pc_source     = 1'b1;
               pc_write_cond = alu_zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, corner sequences and a randomized trace model.
module tb_mc_control_fsm;
   import mc_pkg::*;

   localparam int TO     = 3;
   localparam int OUT_W  = 21;
   localparam int STIM_W = 8;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal_op;
      logic       bus_err;
      logic [3:0] state;
   } out_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      int         wf;
      int         wm;
      int         cyc;
      int         n_rw;
      int         n_mw;
      int         n_pw;
      int         n_pwc;
      int         n_ill;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [5:0] ir_op;
   logic       mem_ready;
   logic       alu_zero;
   logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
   logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op;
   logic       illegal_op, bus_err;
   logic [3:0] state_o;

   int n_checks;
   int n_errors;
   logic [OUT_W-1:0]  exp_q[$];
   logic [STIM_W-1:0] stim_q[$];

   mc_control_fsm #(
      .MEM_TIMEOUT (TO),
      .CNT_W       (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ir_op         (ir_op),
      .mem_ready     (mem_ready),
      .alu_zero      (alu_zero),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_source     (pc_source),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .illegal_op    (illegal_op),
      .bus_err       (bus_err),
      .state_o       (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic out_t dut_out();
      out_t o;
      o.pc_write      = pc_write;
      o.pc_write_cond = pc_write_cond;
      o.pc_source     = pc_source;
      o.i_or_d        = i_or_d;
      o.mem_read      = mem_read;
      o.mem_write     = mem_write;
      o.ir_write      = ir_write;
      o.reg_dst       = reg_dst;
      o.mem_to_reg    = mem_to_reg;
      o.reg_write     = reg_write;
      o.alu_src_a     = alu_src_a;
      o.alu_src_b     = alu_src_b;
      o.alu_op        = alu_op;
      o.illegal_op    = illegal_op;
      o.bus_err       = bus_err;
      o.state         = state_o;
      return o;
   endfunction

   // reference model: expected control word per step of an instruction
   function automatic out_t blank(input state_t s);
      out_t o;
      o       = '0;
      o.state = s;
      return o;
   endfunction

   function automatic out_t fetch_o(input logic rdy);
      out_t o;
      o           = blank(ST_FETCH);
      o.mem_read  = 1'b1;
      o.alu_src_b = 2'b01;
      o.ir_write  = rdy;
      o.pc_write  = rdy;
      return o;
   endfunction

   function automatic out_t mem_o(input logic is_store);
      out_t o;
      o           = blank(is_store ? ST_MEM_WR : ST_MEM_RD);
      o.i_or_d    = 1'b1;
      o.mem_read  = !is_store;
      o.mem_write = is_store;
      return o;
   endfunction

   task automatic push(input logic rdy, input logic [5:0] op, input logic z, input out_t o);
      stim_q.push_back({z, rdy, op});
      exp_q.push_back(o);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Builds the whole cycle trace of one instruction; wf/wm are not-ready cycles before mem_ready.
   task automatic model_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
      out_t o;
      logic st;
      for (int k = 0; k < wf && k < TO; k++) push(1'b0, 6'($urandom_range(0, 63)), z, fetch_o(1'b0));
      if (wf > TO) begin
         o = fetch_o(1'b0);
         o.bus_err = 1'b1;
         push(1'b0, 6'($urandom_range(0, 63)), z, o);
         return;
      end
      push(1'b1, 6'($urandom_range(0, 63)), z, fetch_o(1'b1));
      o = blank(ST_DECODE);
      o.alu_src_b = 2'b11;
      if (!(op == 6'd0 || op == 6'd8 || op == 6'd35 || op == 6'd43 || op == 6'd4)) begin
         o.illegal_op = 1'b1;
         push(rbit(), op, z, o);
         return;
      end
      push(rbit(), op, z, o);
      if (op == 6'd0) begin
         o = blank(ST_EXEC_R); o.alu_src_a = 1'b1; o.alu_op = 2'b10;
         push(rbit(), op, z, o);
         o = blank(ST_R_WB); o.reg_dst = 1'b1; o.reg_write = 1'b1;
         push(rbit(), op, z, o);
      end else if (op == 6'd8) begin
         o = blank(ST_EXEC_I); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
         push(rbit(), op, z, o);
         o = blank(ST_I_WB); o.reg_write = 1'b1;
         push(rbit(), op, z, o);
      end else if (op == 6'd4) begin
         o = blank(ST_BRANCH); o.alu_src_a = 1'b1; o.alu_op = 2'b01;
         o.pc_source = 1'b1; o.pc_write_cond = z;
         push(rbit(), op, z, o);
      end else begin
         st = (op == 6'd43);
         o = blank(ST_MEM_ADDR); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
         push(rbit(), op, z, o);
         for (int k = 0; k < wm && k < TO; k++) push(1'b0, op, z, mem_o(st));
         if (wm > TO) begin
            o = mem_o(st);
            o.bus_err = 1'b1;
            push(1'b0, op, z, o);
            return;
         end
         push(1'b1, op, z, mem_o(st));
         if (!st) begin
            o = blank(ST_LW_WB); o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
            push(rbit(), op, z, o);
         end
      end
   endtask

   // driver + scoreboard: applies queued stimulus at negedge, compares 1 time unit later
   task automatic drain(input string tag);
      logic [STIM_W-1:0] s;
      out_t e;
      while (stim_q.size() > 0) begin
         s         = stim_q.pop_front();
         e         = exp_q.pop_front();
         alu_zero  = s[7];
         mem_ready = s[6];
         ir_op     = s[5:0];
         #1;
         check(tag, 32'(dut_out()), 32'(e));
         @(negedge clk);
      end
   endtask

   task automatic run_row(input int idx, input vec_t v);
      int c, n_rw, n_mw, n_pw, n_pwc, n_ill, n_be;
      logic memop, away, done;
      c = 0; n_rw = 0; n_mw = 0; n_pw = 0; n_pwc = 0; n_ill = 0; n_be = 0;
      away  = 1'b0;
      done  = 1'b0;
      memop = (v.op == 6'd35) || (v.op == 6'd43);
      while (!done && c < 40) begin
         mem_ready = !((c < v.wf) || (memop && c >= v.wf + 3 && c < v.wf + 3 + v.wm));
         ir_op     = v.op;
         alu_zero  = v.z;
         #1;
         n_rw  += int'(reg_write);
         n_mw  += int'(mem_write);
         n_pw  += int'(pc_write);
         n_pwc += int'(pc_write_cond);
         n_ill += int'(illegal_op);
         n_be  += int'(bus_err);
         @(posedge clk);
         c++;
         #1;
         if (state_o != ST_FETCH) away = 1'b1;
         else if (away)           done = 1'b1;
         @(negedge clk);
      end
      check($sformatf("row%0d_done", idx), 32'(done), 32'(1));
      check($sformatf("row%0d_cycles", idx), 32'(c), 32'(v.cyc));
      check($sformatf("row%0d_reg_write", idx), 32'(n_rw), 32'(v.n_rw));
      check($sformatf("row%0d_mem_write", idx), 32'(n_mw), 32'(v.n_mw));
      check($sformatf("row%0d_pc_write", idx), 32'(n_pw), 32'(v.n_pw));
      check($sformatf("row%0d_pc_write_cond", idx), 32'(n_pwc), 32'(v.n_pwc));
      check($sformatf("row%0d_illegal", idx), 32'(n_ill), 32'(v.n_ill));
      check($sformatf("row%0d_bus_err", idx), 32'(n_be), 32'(0));
   endtask

   vec_t       tbl[9];
   logic [5:0] ops[8];
   out_t       o_exp;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      ir_op     = 6'd0;
      mem_ready = 1'b1;
      alu_zero  = 1'b0;

      //            op     z    wf wm cyc rw mw pw pwc ill
      tbl[0] = '{6'd0,  1'b0, 0, 0, 4,  1, 0, 1, 0, 0};
      tbl[1] = '{6'd8,  1'b0, 0, 0, 4,  1, 0, 1, 0, 0};
      tbl[2] = '{6'd35, 1'b0, 0, 2, 7,  1, 0, 1, 0, 0};
      tbl[3] = '{6'd43, 1'b0, 1, 1, 6,  0, 2, 1, 0, 0};
      tbl[4] = '{6'd4,  1'b1, 0, 0, 3,  0, 0, 1, 1, 0};
      tbl[5] = '{6'd4,  1'b0, 0, 0, 3,  0, 0, 1, 0, 0};
      tbl[6] = '{6'd63, 1'b0, 0, 0, 2,  0, 0, 1, 0, 1};
      tbl[7] = '{6'd0,  1'b0, 3, 0, 7,  1, 0, 1, 0, 0};
      tbl[8] = '{6'd35, 1'b1, 2, 3, 10, 1, 0, 1, 0, 0};
      ops = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd63, 6'd2, 6'd13};

      // reset holds every output low, then an illegal opcode pulses once in DECODE
      repeat (2) @(negedge clk);
      #1;
      check("reset_outputs", 32'(dut_out()), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      ir_op = 6'd63;
      #1;
      check("post_reset_fetch", 32'(dut_out()), 32'(fetch_o(1'b1)));
      @(negedge clk);
      #1;
      o_exp = blank(ST_DECODE);
      o_exp.alu_src_b  = 2'b11;
      o_exp.illegal_op = 1'b1;
      check("illegal_decode", 32'(dut_out()), 32'(o_exp));
      @(negedge clk);
      #1;
      check("illegal_back_fetch", 32'(state_o), 32'(ST_FETCH));
      check("illegal_pulse_once", 32'(illegal_op), 32'(0));

      for (int i = 0; i < 9; i++) run_row(i, tbl[i]);

      // fetch timeout: no ready for TO+1 cycles, error on the last, then refetch
      for (int k = 0; k <= TO; k++) begin
         mem_ready = 1'b0;
         ir_op     = 6'($urandom_range(0, 63));
         #1;
         check($sformatf("to_bus_err_%0d", k), 32'(bus_err), 32'(k == TO));
         check($sformatf("to_pc_write_%0d", k), 32'(pc_write), 32'(0));
         check($sformatf("to_state_%0d", k), 32'(state_o), 32'(ST_FETCH));
         @(negedge clk);
      end
      mem_ready = 1'b1;
      ir_op     = 6'd63;
      #1;
      check("to_refetch", 32'(dut_out()), 32'(fetch_o(1'b1)));
      @(negedge clk);
      @(negedge clk);

      // reset while a store waits: write dropped, counter restarts from zero
      ir_op = 6'd43;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mw_in_store", 32'(mem_write), 32'(1));
      check("rst_mw_state", 32'(state_o), 32'(ST_MEM_WR));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mw_forced_low", 32'(mem_write), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k <= TO; k++) begin
         #1;
         check($sformatf("rst_mw_state_%0d", k), 32'(state_o), 32'(ST_FETCH));
         check($sformatf("rst_mw_nowrite_%0d", k), 32'(mem_write), 32'(0));
         check($sformatf("rst_mw_bus_err_%0d", k), 32'(bus_err), 32'(k == TO));
         @(negedge clk);
      end

      // randomized instruction stream against the trace model
      for (int i = 0; i < 80; i++) begin
         int wf, wm;
         wf = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO));
         wm = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO));
         model_instr(ops[$urandom_range(0, 7)], rbit(), wf, wm);
         drain($sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
